// File: rtl/fetch_sched_lru_unit.sv
// fetch_sched_lru_unit
//   Per-core fetch scheduler and L1 instruction cache replacement helper.
//   - A round-robin arbiter picks one fetchable thread each cycle. Threads
//     asleep on an outstanding icache miss are excluded from arbitration.
//   - A sleeping-thread mask is set by reported misses and cleared by fills.
//   - Tree pseudo-LRU state (3 bits per set) picks fill victims and is
//     refreshed on hits and fills.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   fetch_en          threads eligible to fetch
//   grant_oh          one-hot granted thread (combinational), zero if none
//   grant_idx         index of grant_oh, 0 when nothing is granted
//   grant_valid       at least one thread is requesting
//   miss_en           icache miss reported this cycle
//   miss_thread_idx   thread that missed
//   wake_bitmap       threads whose miss was filled this cycle
//   wait_threads      registered sleeping-thread mask
//   access_en         lookup issued, latch access_set
//   access_set        set being looked up
//   update_en         hit reported the cycle after access_en
//   update_way        way that hit
//   fill_en           fill request, latch fill_set
//   fill_set          set to be filled
//   fill_way          victim way of the latched fill set
module fetch_sched_lru_unit #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_SETS    = 64,
  parameter int NUM_WAYS    = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_THREADS-1:0]         fetch_en,
  output logic [NUM_THREADS-1:0]         grant_oh,
  output logic [$clog2(NUM_THREADS)-1:0] grant_idx,
  output logic                           grant_valid,
  input  logic                           miss_en,
  input  logic [$clog2(NUM_THREADS)-1:0] miss_thread_idx,
  input  logic [NUM_THREADS-1:0]         wake_bitmap,
  output logic [NUM_THREADS-1:0]         wait_threads,
  input  logic                           access_en,
  input  logic [$clog2(NUM_SETS)-1:0]    access_set,
  input  logic                           update_en,
  input  logic [1:0]                     update_way,
  input  logic                           fill_en,
  input  logic [$clog2(NUM_SETS)-1:0]    fill_set,
  output logic [1:0]                     fill_way
);

  localparam int TW = $clog2(NUM_THREADS);
  localparam int SW = $clog2(NUM_SETS);

  logic [NUM_THREADS-1:0] req;
  logic [NUM_THREADS-1:0] miss_oh;
  logic [TW-1:0]          last_ptr;
  logic [TW-1:0]          cand;
  logic                   found;

  // LRU bit layout per set: [0] root, [1] ways 0/1, [2] ways 2/3
  logic [2:0]    lru_q [NUM_SETS];
  logic [SW-1:0] access_set_q;
  logic [SW-1:0] fill_set_q;
  logic          fill_pending_q;
  logic          fill_hits_access_set;

  // Moves way to most-recently-used: the root points away from its half,
  // and the leaf of its half points away from it.
  function automatic logic [2:0] make_mru(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] r;
    r    = bits;
    r[0] = ~way[1];
    if (!way[1]) r[1] = ~way[0];
    else         r[2] = ~way[0];
    return r;
  endfunction

  assign req         = fetch_en & ~wait_threads;
  assign grant_valid = |req;
  assign miss_oh     = miss_en ? ({{(NUM_THREADS-1){1'b0}}, 1'b1} << miss_thread_idx)
                               : '0;

  // Round-robin search starting one past the last grant; since the offset
  // runs up to NUM_THREADS the last granted thread is tried last.
  always_comb begin
    grant_oh = '0;
    found    = 1'b0;
    cand     = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      cand = TW'((int'(last_ptr) + i) % NUM_THREADS);
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_oh[cand] = 1'b1;
      end
    end
  end

  // One-hot to index encoder for the grant.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (grant_oh[i]) grant_idx = TW'(i);
    end
  end

  // Pointer resets to the top thread so thread 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            last_ptr <= TW'(NUM_THREADS - 1);
    else if (grant_valid) last_ptr <= grant_idx;
  end

  // Sleep mask: the wake is applied after the miss so a same-cycle
  // miss and wake on one thread leaves it awake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_threads <= '0;
    else       wait_threads <= (wait_threads | miss_oh) & ~wake_bitmap;
  end

  // Victim comes straight from the current bits of the latched fill set.
  assign fill_way = lru_q[fill_set_q][0] ? {1'b1, lru_q[fill_set_q][2]}
                                         : {1'b0, lru_q[fill_set_q][1]};

  assign fill_hits_access_set = fill_pending_q && (fill_set_q == access_set_q);

  // Set latches and the fill-pending flag that qualifies the fill MRU write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      access_set_q   <= '0;
      fill_set_q     <= '0;
      fill_pending_q <= 1'b0;
    end else begin
      if (access_en) access_set_q <= access_set;
      if (fill_en)   fill_set_q   <= fill_set;
      fill_pending_q <= fill_en;
    end
  end

  // LRU state. The hit update is suppressed when the fill update targets
  // the same set, so the fill victim always becomes MRU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) lru_q[s] <= 3'b000;
    end else begin
      if (update_en && !fill_hits_access_set)
        lru_q[access_set_q] <= make_mru(lru_q[access_set_q], update_way);
      if (fill_pending_q)
        lru_q[fill_set_q] <= make_mru(lru_q[fill_set_q], fill_way);
    end
  end

  // Simulation checks: single grant, and only the 4-way tree is supported.
  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_oh));
  a_four_ways:     assert property (@(posedge clk) NUM_WAYS == 4);

endmodule

// File: tb/tb_fetch_sched_lru_unit.sv
// tb_fetch_sched_lru_unit
//   Directed bench for fetch_sched_lru_unit. Each check compares a sampled
//   output against a hand-computed expectation in the cycle it applies to,
//   after the combinational outputs have settled.
module tb_fetch_sched_lru_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] fetch_en;
   logic [3:0] grant_oh;
   logic [1:0] grant_idx;
   logic       grant_valid;
   logic       miss_en;
   logic [1:0] miss_thread_idx;
   logic [3:0] wake_bitmap;
   logic [3:0] wait_threads;
   logic       access_en;
   logic [5:0] access_set;
   logic       update_en;
   logic [1:0] update_way;
   logic       fill_en;
   logic [5:0] fill_set;
   logic [1:0] fill_way;

   int vectors = 0;
   int miscompares = 0;

   fetch_sched_lru_unit #(.NUM_THREADS(4), .NUM_SETS(64), .NUM_WAYS(4)) dut (
      .clk(clk), .reset(reset),
      .fetch_en(fetch_en), .grant_oh(grant_oh), .grant_idx(grant_idx),
      .grant_valid(grant_valid), .miss_en(miss_en),
      .miss_thread_idx(miss_thread_idx), .wake_bitmap(wake_bitmap),
      .wait_threads(wait_threads), .access_en(access_en),
      .access_set(access_set), .update_en(update_en), .update_way(update_way),
      .fill_en(fill_en), .fill_set(fill_set), .fill_way(fill_way)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives every input, then lets combinational outputs settle.
   task automatic applyStimulus(input logic [3:0] fe, input logic me,
                                input logic [1:0] mi, input logic [3:0] wk,
                                input logic ae, input logic [5:0] as,
                                input logic ue, input logic [1:0] uw,
                                input logic fen, input logic [5:0] fs);
      fetch_en        = fe;
      miss_en         = me;
      miss_thread_idx = mi;
      wake_bitmap     = wk;
      access_en       = ae;
      access_set      = as;
      update_en       = ue;
      update_way      = uw;
      fill_en         = fen;
      fill_set        = fs;
      #1;
   endtask

   // Records the outcome of one comparison and reports a mismatch.
   task automatic checkOutput(input string n, input logic ok,
                              input logic [31:0] a, input logic [31:0] e);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic idle();
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
   endtask

   // Reset with a miss and a fill pending to show reset dominates them.
   task automatic resetDut();
      reset = 1'b1;
      applyStimulus(4'b1111, 1'b1, 2'd1, 4'b0000, 1'b1, 6'd9, 1'b0, 2'd0, 1'b1, 6'd9);
      tick();
      checkOutput("reset_wait", wait_threads === 4'h0, 32'(wait_threads), 32'h0);
      checkOutput("reset_fill_way", fill_way === 2'd0, 32'(fill_way), 32'h0);
      tick();
      idle();
      reset = 1'b0;
   endtask

   // Directed scenarios from the test plan.
   initial begin
      int rr_exp[4];
      int alt_exp[3];
      int fill_exp[4];

      reset = 1'b1;
      idle();
      tick();

      resetDut();
      rr_exp = '{1, 2, 3, 0};
      applyStimulus(4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("rr_first", grant_idx === 2'd0, 32'(grant_idx), 32'd0);
      checkOutput("rr_valid", grant_valid === 1'b1, 32'(grant_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput("rr_seq", grant_idx === 2'(rr_exp[i]), 32'(grant_idx), 32'(rr_exp[i]));
      end

      resetDut();
      alt_exp = '{3, 1, 3};
      applyStimulus(4'b1010, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("alt_first", grant_idx === 2'd1, 32'(grant_idx), 32'd1);
      checkOutput("alt_first_oh", grant_oh === 4'b0010, 32'(grant_oh), 32'b0010);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("alt_seq", grant_idx === 2'(alt_exp[i]), 32'(grant_idx), 32'(alt_exp[i]));
      end

      resetDut();
      applyStimulus(4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("miss_c0_grant", grant_idx === 2'd0, 32'(grant_idx), 32'd0);
      checkOutput("miss_c0_wait", wait_threads === 4'h0, 32'(wait_threads), 32'h0);
      tick();
      applyStimulus(4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("miss_sets_wait", wait_threads === 4'b0100, 32'(wait_threads), 32'b0100);
      checkOutput("sleep_grant_a", grant_idx === 2'd1, 32'(grant_idx), 32'd1);
      tick();
      checkOutput("sleep_skip_2", grant_idx === 2'd3, 32'(grant_idx), 32'd3);
      tick();
      checkOutput("sleep_grant_b", grant_idx === 2'd0, 32'(grant_idx), 32'd0);
      tick();
      checkOutput("sleep_grant_c", grant_idx === 2'd1, 32'(grant_idx), 32'd1);
      tick();
      applyStimulus(4'b1111, 1'b0, 2'd0, 4'b0100, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("sleep_skip_2b", grant_idx === 2'd3, 32'(grant_idx), 32'd3);
      checkOutput("wait_before_wake", wait_threads === 4'b0100, 32'(wait_threads), 32'b0100);
      tick();
      applyStimulus(4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("wake_clears", wait_threads === 4'h0, 32'(wait_threads), 32'h0);
      checkOutput("wake_grant_a", grant_idx === 2'd0, 32'(grant_idx), 32'd0);
      tick();
      checkOutput("wake_grant_b", grant_idx === 2'd1, 32'(grant_idx), 32'd1);
      tick();
      applyStimulus(4'b1111, 1'b1, 2'd2, 4'b0100, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("awake_grant_2", grant_idx === 2'd2, 32'(grant_idx), 32'd2);
      tick();
      applyStimulus(4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("miss_wake_same", wait_threads === 4'h0, 32'(wait_threads), 32'h0);
      checkOutput("after_same_grant", grant_idx === 2'd3, 32'(grant_idx), 32'd3);
      tick();
      applyStimulus(4'b1111, 1'b1, 2'd2, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("remiss_grant", grant_idx === 2'd0, 32'(grant_idx), 32'd0);
      tick();
      applyStimulus(4'b0100, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("only_sleeper_valid", grant_valid === 1'b0, 32'(grant_valid), 32'd0);
      checkOutput("only_sleeper_idx", grant_idx === 2'd0, 32'(grant_idx), 32'd0);
      checkOutput("only_sleeper_oh", grant_oh === 4'h0, 32'(grant_oh), 32'h0);
      checkOutput("only_sleeper_wait", wait_threads === 4'b0100, 32'(wait_threads), 32'b0100);
      tick();
      applyStimulus(4'b1111, 1'b0, 2'd0, 4'b0100, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("ptr_held", grant_idx === 2'd1, 32'(grant_idx), 32'd1);
      tick();
      applyStimulus(4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b0, 6'd0);
      checkOutput("rewake_clears", wait_threads === 4'h0, 32'(wait_threads), 32'h0);
      checkOutput("rewake_grant_2", grant_idx === 2'd2, 32'(grant_idx), 32'd2);

      resetDut();
      fill_exp = '{0, 2, 1, 3};
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 6'd5);
      checkOutput("fill_reset_set0", fill_way === 2'd0, 32'(fill_way), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 6'd5);
         checkOutput("fill_seq_set5", fill_way === 2'(fill_exp[i]), 32'(fill_way), 32'(fill_exp[i]));
      end
      tick();
      idle();
      checkOutput("fill_seq_wrap", fill_way === 2'd0, 32'(fill_way), 32'd0);

      tick();
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 6'd7, 1'b0, 2'd0, 1'b0, 6'd0);
      tick();
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b1, 2'd0, 1'b0, 6'd0);
      tick();
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 6'd7);
      tick();
      idle();
      checkOutput("hit_way0_victim", fill_way === 2'd2, 32'(fill_way), 32'd2);

      tick();
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b1, 2'd1, 1'b0, 6'd0);
      tick();
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b0, 2'd0, 1'b1, 6'd7);
      tick();
      idle();
      checkOutput("update_last_set", fill_way === 2'd3, 32'(fill_way), 32'd3);

      tick();
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b1, 6'd3, 1'b0, 2'd0, 1'b1, 6'd3);
      tick();
      applyStimulus(4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0, 1'b1, 2'd3, 1'b1, 6'd3);
      checkOutput("collide_victim", fill_way === 2'd0, 32'(fill_way), 32'd0);
      tick();
      idle();
      checkOutput("collide_fill_wins", fill_way === 2'd2, 32'(fill_way), 32'd2);

      $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
